// File: rtl/bsg_mem_reqrsp_pkg.sv
// rtl/bsg_mem_reqrsp_pkg.sv - shared types and helpers for the masked-write RAM request/response front end
//
// Purpose: FSM state encoding and a safe clog2 for the request/response
// front end and its response queue.
// Ports: none (package).

package bsg_mem_reqrsp_pkg;

  typedef enum logic {
    e_init  = 1'b0,
    e_ready = 1'b1
  } state_e;

  // Address/pointer widths never drop below one bit, even for depth 1.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small register-based first-in first-out queue with valid/yumi output
//
// Purpose: holds read responses until the consumer takes them.
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   v_i, ready_o, data_i enqueue side (ready_o = not full)
//   v_o, data_o, yumi_i  dequeue side (v_o = not empty, yumi_i pops head)

module bsg_fifo_1r1w_small
  import bsg_mem_reqrsp_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = safe_clog2(els_p);
  localparam int cnt_width_lp = safe_clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  logic [width_p-1:0]      r_mem [els_p];
  logic [ptr_width_lp-1:0] r_wptr;
  logic [ptr_width_lp-1:0] r_rptr;
  logic [cnt_width_lp-1:0] r_count;

  logic w_enq;
  logic w_deq;

  assign ready_o = (r_count != full_cnt_lp);
  assign v_o     = (r_count != '0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= (r_wptr == last_ptr_lp) ? '0 : r_wptr + ptr_width_lp'(1);
      if (w_deq) r_rptr <= (r_rptr == last_ptr_lp) ? '0 : r_rptr + ptr_width_lp'(1);
      if (w_enq && !w_deq) r_count <= r_count + cnt_width_lp'(1);
      else if (!w_enq && w_deq) r_count <= r_count - cnt_width_lp'(1);
    end
  end

  // Storage needs no reset: the cleared count hides stale entries.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_reqrsp.sv
// rtl/bsg_mem_1rw_sync_mask_write_bit_reqrsp.sv - ready/valid front end for a 1rw bit-masked synchronous RAM
//
// Purpose: zero-sweeps the RAM after reset, then forwards one request per
// cycle to the RAM port and queues read data behind a credit counter.
// Optional macro BSG_MEM_REQRSP_WRITE_ACK_EN: writes also take a credit
// and return a zero response in order with reads.
// Ports:
//   clk_i, reset_n_i                      clock, asynchronous active-low reset
//   v_i, ready_o, w_i, addr_i,
//   data_i, w_mask_i                      request channel
//   v_o, data_o, yumi_i                   response channel
//   mem_v_o, mem_w_o, mem_addr_o,
//   mem_data_o, mem_w_mask_o, mem_data_i  RAM port (read data one cycle later)

module bsg_mem_1rw_sync_mask_write_bit_reqrsp
  import bsg_mem_reqrsp_pkg::*;
#(
  parameter int width_p   = 32,
  parameter int els_p     = 16,
  parameter int credits_p = 3
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  output logic                             ready_o,
  input  logic                             w_i,
  input  logic [safe_clog2(els_p)-1:0]     addr_i,
  input  logic [width_p-1:0]               data_i,
  input  logic [width_p-1:0]               w_mask_i,
  output logic                             v_o,
  output logic [width_p-1:0]               data_o,
  input  logic                             yumi_i,
  output logic                             mem_v_o,
  output logic                             mem_w_o,
  output logic [safe_clog2(els_p)-1:0]     mem_addr_o,
  output logic [width_p-1:0]               mem_data_o,
  output logic [width_p-1:0]               mem_w_mask_o,
  input  logic [width_p-1:0]               mem_data_i
);

  localparam int addr_width_lp = safe_clog2(els_p);
  localparam int cnt_width_lp  = safe_clog2(credits_p + 1);
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0]  credits_lp   = cnt_width_lp'(credits_p);

  typedef struct packed {
    logic                     w;
    logic [addr_width_lp-1:0] addr;
    logic [width_p-1:0]       data;
    logic [width_p-1:0]       mask;
  } req_s;

  state_e                   r_state;
  logic [addr_width_lp-1:0] r_sweep_cnt;
  logic [cnt_width_lp-1:0]  r_credits;
  logic                     r_rd_pending;
  logic                     r_ready_o;
`ifdef BSG_MEM_REQRSP_WRITE_ACK_EN
  logic                     r_rsp_zero;
`endif

  state_e                   w_state_next;
  logic [cnt_width_lp-1:0]  w_credits_next;
  logic                     w_accept;
  logic                     w_take_credit;
  logic                     w_mem_v;
  logic                     w_fifo_ready;
  logic [width_p-1:0]       w_rsp_data;
  req_s                     w_req;
  req_s                     w_mem_req;

  assign w_req = '{w: w_i, addr: addr_i, data: data_i, mask: w_mask_i};

  // r_ready_o is the registered "credit available" term; writes without
  // acks bypass it, which only adds a dependence on w_i.
`ifdef BSG_MEM_REQRSP_WRITE_ACK_EN
  assign ready_o       = r_ready_o;
  assign w_take_credit = w_accept;
  assign w_rsp_data    = r_rsp_zero ? '0 : mem_data_i;
`else
  assign ready_o       = r_ready_o | (w_i & (r_state == e_ready));
  assign w_take_credit = w_accept & ~w_i;
  assign w_rsp_data    = mem_data_i;
`endif

  assign w_accept = v_i & ready_o;

  always_comb begin
    w_credits_next = r_credits;
    if (w_take_credit && !yumi_i)      w_credits_next = r_credits + cnt_width_lp'(1);
    else if (!w_take_credit && yumi_i) w_credits_next = r_credits - cnt_width_lp'(1);
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == e_init && r_sweep_cnt == last_addr_lp) w_state_next = e_ready;
  end

  always_comb begin
    w_mem_req = w_req;
    w_mem_v   = w_accept;
    if (r_state == e_init) begin
      w_mem_req = '{w: 1'b1, addr: r_sweep_cnt, data: '0, mask: '1};
      w_mem_v   = 1'b1;
    end
  end

  // The sweep state is also the reset state, so the RAM port is gated
  // by reset to keep it idle while reset is held.
  assign mem_v_o      = reset_n_i & w_mem_v;
  assign mem_w_o      = mem_v_o & w_mem_req.w;
  assign mem_addr_o   = w_mem_req.addr;
  assign mem_data_o   = w_mem_req.data;
  assign mem_w_mask_o = w_mem_req.mask;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= e_init;
      r_sweep_cnt  <= '0;
      r_credits    <= '0;
      r_rd_pending <= 1'b0;
      r_ready_o    <= 1'b0;
`ifdef BSG_MEM_REQRSP_WRITE_ACK_EN
      r_rsp_zero   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_credits    <= w_credits_next;
      r_rd_pending <= w_take_credit;
      r_ready_o    <= (w_state_next == e_ready) && (w_credits_next < credits_lp);
      if (r_state == e_init)
        r_sweep_cnt <= (r_sweep_cnt == last_addr_lp) ? '0 : r_sweep_cnt + addr_width_lp'(1);
`ifdef BSG_MEM_REQRSP_WRITE_ACK_EN
      r_rsp_zero   <= w_i;
`endif
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p(width_p),
    .els_p  (credits_p)
  ) rsp_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (r_rd_pending),
    .ready_o  (w_fifo_ready),
    .data_i   (w_rsp_data),
    .v_o      (v_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i)
  );

`ifndef BSG_HIDE_FROM_SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o is low");
      assert (!(w_accept && ({1'b0, addr_i} >= (addr_width_lp + 1)'(els_p))))
        else $error("accepted request address out of range");
      assert (!(r_rd_pending && !w_fifo_ready))
        else $error("response queue overflow");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_reqrsp.sv
// tb/tb_bsg_mem_1rw_sync_mask_write_bit_reqrsp.sv - randomized self-checking bench for the RAM request/response front end

module tb_bsg_mem_1rw_sync_mask_write_bit_reqrsp;

  localparam int W  = 32;
  localparam int E  = 16;
  localparam int C  = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          v_i, w_i, yumi_i;
  logic [AW-1:0] addr_i;
  logic [W-1:0]  data_i, w_mask_i;
  logic          ready_o, v_o, mem_v_o, mem_w_o;
  logic [W-1:0]  data_o, mem_data_o, mem_w_mask_o, mem_data_i;
  logic [AW-1:0] mem_addr_o;

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_bit_reqrsp #(
    .width_p(W), .els_p(E), .credits_p(C)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v_i), .ready_o(ready_o), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .w_mask_i(w_mask_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
  );

  // Environment RAM: filled with garbage during reset so the sweep is observable.
  logic [W-1:0] ram [E];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < E; i++) ram[i] <= $urandom;
      mem_data_i <= $urandom;
    end else if (mem_v_o) begin
      if (mem_w_o) ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else         mem_data_i <= ram[mem_addr_o];
    end
  end

  // Reference model: word array plus an ordered list of promised responses.
  typedef struct {
    logic [W-1:0] d;
    int           rdy;
  } rsp_t;

  logic [W-1:0] ref_mem [E];
  rsp_t         q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  int           n_acc = 0;
  int           n_pop = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic reset_and_sweep();
    v_i = 0; w_i = 0; yumi_i = 0; addr_i = '0; data_i = '0; w_mask_i = '0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_v_o", v_o, 0);
    chk("rst_mem_v", mem_v_o, 0);
    chk("rst_mem_w", mem_w_o, 0);
    q.delete();
    for (int i = 0; i < E; i++) ref_mem[i] = '0;
    reset_n = 1;
    for (int i = 0; i < E; i++) begin
      @(negedge clk);
      chk("sweep_mem_v", mem_v_o, 1);
      chk("sweep_mem_w", mem_w_o, 1);
      chk("sweep_addr", mem_addr_o, i);
      chk("sweep_data", mem_data_o, 0);
      chk("sweep_mask", mem_w_mask_o, {W{1'b1}});
      chk("sweep_ready", ready_o, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] m, input logic y);
    logic exp_rdy, exp_v, acc;
    exp_v = (q.size() > 0) && (q[0].rdy <= cyc);
`ifdef BSG_MEM_REQRSP_WRITE_ACK_EN
    exp_rdy = (q.size() < C);
`else
    exp_rdy = w || (q.size() < C);
`endif
    v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m;
    yumi_i = y & exp_v;
    acc = v & exp_rdy;
    @(negedge clk);
    chk("ready_o", ready_o, exp_rdy);
    chk("v_o", v_o, exp_v);
    if (exp_v) chk("data_o", data_o, q[0].d);
    chk("mem_v_o", mem_v_o, acc);
    if (acc) begin
      chk("mem_w_o", mem_w_o, w);
      chk("mem_addr_o", mem_addr_o, a);
      if (w) begin
        chk("mem_data_o", mem_data_o, d);
        chk("mem_w_mask_o", mem_w_mask_o, m);
      end
    end
    @(posedge clk);
    if (yumi_i) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (acc) begin
      n_acc++;
      if (w) begin
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
`ifdef BSG_MEM_REQRSP_WRITE_ACK_EN
        q.push_back('{d: '0, rdy: cyc + 2});
`endif
      end else begin
        q.push_back('{d: ref_mem[a], rdy: cyc + 2});
      end
    end
    cyc++;
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic y);
    cycle(1'b1, 1'b0, a, $urandom, $urandom, y);
  endtask

  task automatic idle(input int n, input logic y);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, y);
  endtask

  int acc0, pop0;

  initial begin
    reset_and_sweep();

    // Fresh after sweep: every word reads zero.
    rd(4'd3, 1'b0);
    rd(4'd15, 1'b0);
    idle(4, 1'b1);

    // Masked write followed immediately by a read of the same word.
    cycle(1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0);
    rd(4'd5, 1'b0);
    idle(4, 1'b1);

    // Backpressure: only three reads fit without consumption.
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) rd(4'(i), 1'b0);
    chk("bp_accepted", n_acc - acc0, 3);
    idle(1, 1'b1);
    rd(4'd7, 1'b0);
    idle(6, 1'b1);

    // Throughput: one read per cycle with the consumer always ready.
    acc0 = n_acc;
    pop0 = n_pop;
    for (int i = 0; i < 20; i++) rd(4'(i % E), 1'b1);
    idle(2, 1'b1);
    chk("tput_accepted", n_acc - acc0, 20);
    chk("tput_responses", n_pop - pop0, 20);

    // Read, write, read interleaved.
    rd(4'd1, 1'b1);
    cycle(1'b1, 1'b1, 4'd2, 32'hA5A5_5A5A, 32'hFF00_FF00, 1'b1);
    rd(4'd2, 1'b1);
    idle(4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom % 2), 1'($urandom % 3 == 0), 4'($urandom_range(0, E - 1)),
            $urandom, $urandom, 1'($urandom % 4 != 0));
    idle(6, 1'b1);

    // Reset mid-operation with two reads outstanding.
    cycle(1'b1, 1'b1, 4'd9, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    rd(4'd9, 1'b0);
    rd(4'd9, 1'b0);
    idle(1, 1'b0);
    #2;
    reset_n = 0;
    #1;
    chk("midrst_v_o", v_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_mem_v", mem_v_o, 0);
    reset_and_sweep();
    idle(6, 1'b1);
    rd(4'd9, 1'b1);
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_bit_reqrsp.md
Name: bsg_mem_1rw_sync_mask_write_bit_reqrsp

Overview:
Requester-side front end for a single-port synchronous bit-masked-write RAM. It accepts ready/valid read and write requests and drives the RAM port with at most one operation per cycle. Read data returned one cycle later is captured into a credit-protected response queue, presented valid/yumi. After reset it sweeps the RAM to zero before accepting traffic.

Parameters:
- width_p, none (must be set), data and mask width in bits.
- els_p, none (must be set), RAM depth in words; must be at least 2.
- credits_p, 3, response queue depth and maximum number of reads in flight plus reads queued.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width; derived, not overridable.

Ports:
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  request valid.
- ready_o  out  1  request ready.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  addr_width_lp  request address.
- data_i  in  width_p  write data.
- w_mask_i  in  width_p  per-bit write enable.
- v_o  out  1  response valid.
- data_o  out  width_p  read data.
- yumi_i  in  1  response consumed; legal only while v_o = 1.
- mem_v_o  out  1  RAM access enable.
- mem_w_o  out  1  RAM write.
- mem_addr_o  out  addr_width_lp  RAM address.
- mem_data_o  out  width_p  RAM write data.
- mem_w_mask_o  out  width_p  RAM bit mask.
- mem_data_i  in  width_p  RAM read data, valid the cycle after a read.

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous and active-low, reset_n_i.
- While reset_n_i = 0:
  - ready_o = 0, v_o = 0, mem_v_o = 0, mem_w_o = 0.
  - Sweep counter = 0, credit count = 0, read-in-flight flag = 0.
  - Response queue emptied.
  - State = INIT.
- State INIT:
  - mem_v_o = 1, mem_w_o = 1, mem_addr_o = sweep counter, mem_data_o = 0, mem_w_mask_o = all ones.
  - ready_o = 0.
  - Counter increments each cycle. When counter = els_p-1, go to READY the next cycle.
  - Sweep takes exactly els_p cycles.
- State READY:
  - ready_o = (credit count < credits_p) for reads. Writes are always ready unless a write ack is enabled (see Optional Feature).
  - ready_o has no combinational dependence on yumi_i or v_i.
  - Request accepted when v_i & ready_o. In the same cycle: mem_v_o = 1, mem_w_o = w_i, and addr/data/mask passed through combinationally.
  - When no request is accepted, mem_v_o = 0.
- Reads:
  - Accepted read sets the in-flight flag and increments the credit count.
  - Next cycle, mem_data_i is enqueued.
  - v_o asserts 2 cycles after acceptance.
  - Responses are returned in request order.
- Credits:
  - Decrement on yumi_i.
  - On a simultaneous accepted read and yumi_i, the count is unchanged.
  - Count never exceeds credits_p; the queue can never overflow.
  - With credits_p = 3 and yumi_i held high, one read is sustained per cycle.
- Writes: take effect at the RAM edge. A read issued the next cycle returns the new masked data; no forwarding is needed.
- Reset mid-operation: in-flight read data is discarded, queued responses are dropped, and the FSM returns to INIT.
- Assertions (simulation only, hidden under BSG_HIDE_FROM_SYNTHESIS):
  - yumi_i while v_o = 0.
  - addr_i >= els_p on an accepted request.

Optional Feature:
Macro BSG_MEM_REQRSP_WRITE_ACK_EN.
- Defined:
  - Every accepted write also consumes a credit and enqueues a response with data_o = 0, in order with reads.
  - ready_o = (credit count < credits_p) for all requests.
- Undefined:
  - Writes produce no response and consume no credit.
  - Writes are accepted in READY regardless of credit count.

Decomposition:
- Package bsg_mem_reqrsp_pkg:
  - enum state_e {e_init, e_ready}.
  - Packed request struct {w, addr, data, mask}, parameterised by width through a localparam-sized typedef in the module.
- Sub-module: the response queue is bsg_fifo_1r1w_small with els_p = credits_p and width_p = width_p. Its ready output is unused because credits guarantee space.
- No other sub-module.

Test Plan:
- Reset and sweep, els_p = 16: release reset -> 16 cycles of mem_v_o = 1, mem_w_o = 1, addr 0..15, data 0. ready_o rises in cycle 17. Any subsequent read returns 0.
- Masked write then read: write addr 5, data 0xFFFF_FFFF, mask 0x0000_FFFF; read addr 5 the next cycle -> data_o = 0x0000_FFFF, v_o exactly 2 cycles after read accept.
- Backpressure: yumi_i = 0, issue 5 reads -> exactly 3 accepted, ready_o = 0 after the third. Assert yumi_i for one cycle -> ready_o = 1 the next cycle; responses arrive in order.
- Throughput: yumi_i tied high, 20 back-to-back reads to addresses 0..19 mod els_p -> 20 responses on 20 consecutive cycles, ready_o never low.
- Reset mid-operation: 2 reads outstanding, pulse reset_n_i low asynchronously -> v_o = 0 immediately, queue empty, full re-sweep, no stale response appears.
- With BSG_MEM_REQRSP_WRITE_ACK_EN: read, write, read interleaved -> three responses in order, middle one with data_o = 0.
